// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared types for the iterative multiply/divide unit.
//   MduOp    - 4-bit operation code carried in EXSignal.mduOp
//   MduState - sequencer state of mdu_iter
//   EXSignal - EX-stage control fields that drive the MDU
package mdu_iter_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MTHI  = 4'd4,
        MTLO  = 4'd5,
        MADD  = 4'd6,
        MADDU = 4'd7,
        MSUB  = 4'd8,
        MSUBU = 4'd9
    } MduOp;

    // State names carry a prefix because DIV is already an MduOp literal.
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } MduState;

    typedef struct packed {
        logic mduStart;
        MduOp mduOp;
    } EXSignal;

    function automatic logic op_is_signed(MduOp code);
        return (code == MULT) || (code == DIV) || (code == MADD) || (code == MSUB);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: issue/result bundle between EX and the MDU.
//   master (EX side): drives start, op, rsData, rtData, flush; reads busy, hi, lo
//   slave  (MDU)    : the reverse
interface mdu_iter_if
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    MduOp             op;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rsData, rtData, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rsData, rtData, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_iter_divider.sv
// mdu_divider: serial restoring radix-2 divider, one quotient bit per cycle.
//   clk, rstN           - clock, async active-low reset
//   load                - capture operands and start (WIDTH cycles)
//   abort               - drop the in-flight division
//   sign                - treat operands as two's complement
//   dividend, divisor   - operands, sampled only on load
//   quotient, remainder - final result, valid while done is high
//   done                - high in the last iteration cycle
// The outputs are the combinational result of the final iteration with the
// sign fix-up applied, so the owner can capture them at the completing edge.
module mdu_divider
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic             abort,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int unsigned SW = $clog2(WIDTH);

    logic             active;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] raw_a;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             ovf;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign a_neg = sign & dividend[WIDTH-1];
    assign b_neg = sign & divisor[WIDTH-1];

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        fits     = shifted >= {1'b0, dsr};
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

    assign done = active && (step == SW'(WIDTH - 1));

    always_comb begin
        quotient  = neg_q ? -quo_next : quo_next;
        remainder = neg_r ? -rem_next : rem_next;
        if (div_zero) begin
            quotient  = '1;
            remainder = raw_a;
        end else if (ovf) begin
            quotient  = {1'b1, {(WIDTH-1){1'b0}}};
            remainder = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            active   <= 1'b0;
            step     <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            raw_a    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (load) begin
            active   <= 1'b1;
            step     <= '0;
            rem      <= '0;
            quo      <= a_neg ? -dividend : dividend;
            dsr      <= b_neg ? -divisor : divisor;
            raw_a    <= dividend;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (divisor == '0);
            ovf      <= sign && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        end else if (active) begin
            rem  <= rem_next;
            quo  <= quo_next;
            step <= step + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning the HI/LO registers.
//   clk, rstN - clock, async active-low reset
//   bus       - mdu_iter_if slave: start/op/rsData/rtData/flush in,
//               busy/hi/lo out
// Multiply holds busy for MUL_LAT cycles, divide for WIDTH cycles; MTHI/MTLO
// write in zero busy cycles. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/
// MSUBU (accumulate into {hi,lo}); otherwise those codes are ignored.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input logic       clk,
    input logic       rstN,
    mdu_iter_if.slave bus
);
    localparam int unsigned CW = $clog2(MUL_LAT + 1);

    MduState            state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [WIDTH-1:0]   hi_q, hi_next;
    logic [WIDTH-1:0]   lo_q, lo_next;
    MduOp               op_q, op_next;
    logic [WIDTH-1:0]   opa, opa_next;
    logic [WIDTH-1:0]   opb, opb_next;

    logic               issue;
    logic               is_mul_op;
    logic               is_div_op;
    logic               dv_load;
    logic               dv_sign;
    logic               dv_done;
    logic [WIDTH-1:0]   dv_q;
    logic [WIDTH-1:0]   dv_r;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mul_result;

`ifdef MDU_MADD_EN
    assign is_mul_op = bus.op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
`else
    assign is_mul_op = bus.op inside {MULT, MULTU};
`endif
    assign is_div_op = bus.op inside {DIV, DIVU};
    // flush outranks a same-cycle start
    assign issue     = (state == S_IDLE) && bus.start && !bus.flush;
    assign dv_load   = issue && is_div_op;
    assign dv_sign   = (bus.op == DIV);

    mdu_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rstN     (rstN),
        .load     (dv_load),
        .abort    (bus.flush),
        .sign     (dv_sign),
        .dividend (bus.rsData),
        .divisor  (bus.rtData),
        .quotient (dv_q),
        .remainder(dv_r),
        .done     (dv_done)
    );

    // Sign/zero extension to 2*WIDTH makes a truncated unsigned multiply
    // produce the correct signed or unsigned full-width product.
    always_comb begin
        ext_a      = op_is_signed(op_q) ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
        ext_b      = op_is_signed(op_q) ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
        product    = ext_a * ext_b;
        mul_result = product;
`ifdef MDU_MADD_EN
        if (op_q inside {MADD, MADDU}) begin
            mul_result = {hi_q, lo_q} + product;
        end else if (op_q inside {MSUB, MSUBU}) begin
            mul_result = {hi_q, lo_q} - product;
        end
`endif
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi_q;
        lo_next    = lo_q;
        op_next    = op_q;
        opa_next   = opa;
        opb_next   = opb;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    if (is_mul_op) begin
                        state_next = S_MUL;
                        cnt_next   = CW'(MUL_LAT - 1);
                        op_next    = bus.op;
                        opa_next   = bus.rsData;
                        opb_next   = bus.rtData;
                    end else if (is_div_op) begin
                        state_next = S_DIV;
                    end else if (bus.op == MTHI) begin
                        hi_next = bus.rsData;
                    end else if (bus.op == MTLO) begin
                        lo_next = bus.rsData;
                    end
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    state_next         = S_IDLE;
                    {hi_next, lo_next} = mul_result;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    state_next = S_IDLE;
                end else if (dv_done) begin
                    state_next = S_IDLE;
                    hi_next    = dv_r;
                    lo_next    = dv_q;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            op_q  <= MULT;
            opa   <= '0;
            opb   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            op_q  <= op_next;
            opa   <= opa_next;
            opb   <= opb_next;
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 5;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus();

    mdu_iter #(
        .WIDTH  (W),
        .MUL_LAT(LAT)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    typedef struct {
        MduOp        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input MduOp op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input int unsigned lat);
        vecs.push_back('{op: op, a: a, b: b, exp_hi: h, exp_lo: l, lat: lat});
    endtask

    // Called #1 after an edge; the next edge samples the issue.
    task automatic issue(input MduOp op, input logic [31:0] a, input logic [31:0] b);
        bus.op     = op;
        bus.rsData = a;
        bus.rtData = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.rsData = $urandom;
        bus.rtData = $urandom;
    endtask

    task automatic wait_idle(output int unsigned n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t        e;
        int unsigned n;
        sb.push_back('{hi: v.exp_hi, lo: v.exp_lo, lat: v.lat});
        issue(v.op, v.a, v.b);
        wait_idle(n);
        e = sb.pop_front();
        check($sformatf("%s busy_cycles", name), 64'(n), 64'(e.lat));
        check($sformatf("%s hi", name), 64'(bus.hi), 64'(e.hi));
        check($sformatf("%s lo", name), 64'(bus.lo), 64'(e.lo));
    endtask

    initial begin
        int unsigned n;
        vec_t        v;

        rstN       = 1'b0;
        bus.start  = 1'b0;
        bus.op     = MULT;
        bus.rsData = '0;
        bus.rtData = '0;
        bus.flush  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset hi", 64'(bus.hi), 64'(0));
        check("reset lo", 64'(bus.lo), 64'(0));
        rstN = 1'b1;
        @(posedge clk);
        #1;

        add(MULT,  32'd3,        32'd4,        32'h0000_0000, 32'd12,        LAT);
        add(MULT,  32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT);
        add(MULTU, 32'hFFFF_FFFF, 32'd2,       32'h0000_0001, 32'hFFFF_FFFE, LAT);
        add(DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, W);
        add(DIVU,  32'd7,        32'd0,        32'd7,         32'hFFFF_FFFF, W);
        add(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h8000_0000, W);
        add(DIV,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, W);
        add(DIVU,  32'd100,      32'd7,        32'd2,         32'd14,        W);
        add(DIV,   32'hFFFF_FFF8, 32'd0,       32'hFFFF_FFF8, 32'hFFFF_FFFF, W);
        add(MTHI,  32'h1234,     32'd0,        32'h1234,      32'hFFFF_FFFF, 0);
        add(MTLO,  32'h5678,     32'd0,        32'h1234,      32'h5678,      0);
        add(MduOp'(4'hF), 32'd9, 32'd9,        32'h1234,      32'h5678,      0);
        add(DIVU,  32'hFFFF_FFFF, 32'd1,       32'h0,         32'hFFFF_FFFF, W);
        add(DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,       W);
        add(MULTU, 32'h1_0000,   32'h1_0000,   32'd1,         32'd0,         LAT);
`ifdef MDU_MADD_EN
        add(MTHI,  32'd0,        32'd0,        32'd0,         32'd0,         0);
        add(MTLO,  32'd10,       32'd0,        32'd0,         32'd10,        0);
        add(MADD,  32'd3,        32'd4,        32'd0,         32'd22,        LAT);
        add(MSUBU, 32'd1,        32'd23,       32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
        add(MSUB,  32'hFFFF_FFFF, 32'd2,       32'd0,         32'd1,         LAT);
`else
        add(MADD,  32'd3,        32'd4,        32'd1,         32'd0,         0);
        add(MSUBU, 32'd1,        32'd23,       32'd1,         32'd0,         0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed mid-divide must neither extend nor queue anything
        sb.push_back('{hi: 32'd2, lo: 32'd14, lat: W});
        issue(DIVU, 32'd100, 32'd7);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (n == 10) begin
                bus.op     = MULT;
                bus.rsData = 32'd3;
                bus.rtData = 32'd3;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check("midstart busy_cycles", 64'(n), 64'(e.lat));
            check("midstart hi", 64'(bus.hi), 64'(e.hi));
            check("midstart lo", 64'(bus.lo), 64'(e.lo));
        end
        @(posedge clk);
        #1;
        check("midstart no_queue", 64'(bus.busy), 64'(0));

        // flush together with start in IDLE: nothing issues
        v = '{op: MTHI, a: 32'h1234, b: 32'd0, exp_hi: 32'h1234, exp_lo: 32'd14, lat: 0};
        run_vec(v, "mthi");
        bus.flush = 1'b1;
        issue(MULT, 32'd7, 32'd7);
        bus.flush = 1'b0;
        check("flush_start busy", 64'(bus.busy), 64'(0));
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("flush_start hi", 64'(bus.hi), 64'(32'h1234));
        check("flush_start lo", 64'(bus.lo), 64'(32'd14));

        // multiply flushed on its third busy cycle
        issue(MULT, 32'd9, 32'd9);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_mul3 busy", 64'(bus.busy), 64'(0));
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("flush_mul3 hi", 64'(bus.hi), 64'(32'h1234));
        check("flush_mul3 lo", 64'(bus.lo), 64'(32'd14));

        // flush on the completing cycle discards the result
        issue(MULT, 32'd9, 32'd9);
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        check("flush_last still_busy", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_last busy", 64'(bus.busy), 64'(0));
        check("flush_last hi", 64'(bus.hi), 64'(32'h1234));
        check("flush_last lo", 64'(bus.lo), 64'(32'd14));

        // divide flushed midway, then a fresh divide runs its full length
        issue(DIV, 32'd50, 32'd5);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_div busy", 64'(bus.busy), 64'(0));
        check("flush_div lo", 64'(bus.lo), 64'(32'd14));
        v = '{op: DIV, a: 32'hFFFF_FFF9, b: 32'd2, exp_hi: 32'hFFFF_FFFF, exp_lo: 32'hFFFF_FFFD, lat: W};
        run_vec(v, "div_after_flush");

        // asynchronous reset in the middle of a divide
        issue(DIVU, 32'd100, 32'd7);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rstN = 1'b0;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'(0));
        check("rst_mid hi", 64'(bus.hi), 64'(0));
        check("rst_mid lo", 64'(bus.lo), 64'(0));
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        v = '{op: MULT, a: 32'd3, b: 32'd4, exp_hi: 32'd0, exp_lo: 32'd12, lat: LAT};
        run_vec(v, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
